// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the unified memory and the arbiter.
// The master side is the pipeline plus the memory; the slave side is the arbiter.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_kill;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_stall;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, if_stall, d_ack, d_rdata, d_stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, if_stall, d_ack, d_rdata, d_stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access.
// One fixed-latency transaction at a time; grants alternate when both stages contend.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input logic                  clk,
    input logic                  rst,
    unified_mem_arbiter_if.slave bus
);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_grant_q, last_grant_d;
    logic              kill_q, kill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              grant_data;
    logic              kill_now;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        kill_d       = kill_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        // Data wins a tie unless it won the previous grant.
        grant_data   = bus.d_req & (~bus.if_req | (last_grant_q == OWN_FETCH));
        kill_now     = kill_q | ((owner_q == OWN_FETCH) & bus.if_kill);

        case (state_q)
            IDLE: begin
                if (bus.if_req | bus.d_req) begin
                    owner_d      = grant_data ? OWN_DATA : OWN_FETCH;
                    last_grant_d = owner_d;
                    kill_d       = 1'b0;
                    mem_addr_d   = grant_data ? bus.d_addr : bus.if_addr;
                    mem_wdata_d  = grant_data ? bus.d_wdata : '0;
                    we_d         = grant_data & bus.d_we;
                    mem_we_d     = grant_data & bus.d_we;
                    mem_en_d     = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                cnt_d    = CNT_W'(MEM_LAT);
                kill_d   = kill_now;
                state_d  = WAIT;
            end
            WAIT: begin
                cnt_d  = cnt_q - 1'b1;
                kill_d = kill_now;
                // Read data is valid this cycle; register it straight into the response.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                    if (owner_q == OWN_DATA) begin
                        d_ack_d = 1'b1;
                        if (!we_q) d_rdata_d = bus.mem_rdata;
                    end else if (!kill_now) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end
            end
            RESP: begin
                kill_d  = kill_now;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_FETCH;
            last_grant_q <= OWN_FETCH;
            kill_q       <= 1'b0;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            kill_q       <= kill_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_stall  = bus.if_req & ~if_ack_q;
    assign bus.d_stall   = bus.d_req & ~d_ack_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: three instances (MEM_LAT 2, 1, 15) each with a memory model;
// instance 0 is scoreboarded, all instances get the reset-mid-transaction check.
module tb_unified_mem_arbiter;
    localparam int NI = 3;

    typedef struct packed {
        logic        we;
        logic [31:0] data;
    } dexp_t;

    logic          clk = 1'b0;
    logic [NI-1:0] rst = '1;
    int            cyc = 0;

    logic [NI-1:0] if_req = '0, if_kill = '0, d_req = '0, d_we = '0;
    logic [31:0]   if_addr [NI];
    logic [31:0]   d_addr  [NI];
    logic [31:0]   d_wdata [NI];
    logic [NI-1:0] if_ack, if_stall, d_ack, d_stall, mem_en, mem_we;
    logic [31:0]   if_rdata  [NI];
    logic [31:0]   d_rdata   [NI];
    logic [31:0]   mem_addr  [NI];
    logic [31:0]   mem_wdata [NI];

    int            n_chk = 0, n_fail = 0;
    logic [31:0]   fq [$];
    dexp_t         dq [$];
    int            ack_log [$];
    logic [31:0]   sb_mem [256];
    logic [31:0]   last_load = '0;
    int            men_cnt = 0, men_cyc = 0, wr_cnt = 0;
    logic [31:0]   wr_addr = '0, wr_data = '0;
    logic [31:0]   fe;
    dexp_t         de;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h10) ? 32'h8C01_0004 : {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    function automatic logic [31:0] wd(input logic [31:0] a);
        return (a == 32'h24) ? 32'hDEAD_BEEF : ~a;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
        logic [31:0] st [256];
        logic [31:0] rdata;
        logic [31:0] ra;
        int          rdy;

        assign bus.if_req    = if_req[g];
        assign bus.if_addr   = if_addr[g];
        assign bus.if_kill   = if_kill[g];
        assign bus.d_req     = d_req[g];
        assign bus.d_we      = d_we[g];
        assign bus.d_addr    = d_addr[g];
        assign bus.d_wdata   = d_wdata[g];
        assign bus.mem_rdata = rdata;
        assign if_ack[g]     = bus.if_ack;
        assign if_stall[g]   = bus.if_stall;
        assign d_ack[g]      = bus.d_ack;
        assign d_stall[g]    = bus.d_stall;
        assign mem_en[g]     = bus.mem_en;
        assign mem_we[g]     = bus.mem_we;
        assign if_rdata[g]   = bus.if_rdata;
        assign d_rdata[g]    = bus.d_rdata;
        assign mem_addr[g]   = bus.mem_addr;
        assign mem_wdata[g]  = bus.mem_wdata;

        unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) dut (
            .clk (clk),
            .rst (rst[g]),
            .bus (bus)
        );

        initial begin
            rdy   = -1;
            ra    = '0;
            rdata = '0;
            for (int k = 0; k < 256; k++) st[k] = mem_fn(32'(k * 4));
        end

        // Memory: data is valid only in cycle E+L, garbage otherwise.
        always @(negedge clk) begin
            rdata <= (cyc == rdy) ? st[ra[9:2]] : (32'hBAD0_0000 ^ 32'(cyc));
            if (bus.mem_en) begin
                if (bus.mem_we) st[bus.mem_addr[9:2]] <= bus.mem_wdata;
                else begin
                    rdy <= cyc + L;
                    ra  <= bus.mem_addr;
                end
            end
        end
    end

    // Scoreboard monitor for instance 0.
    always @(negedge clk) begin
        if (rst[0]) last_load <= '0;
        else begin
            if (if_ack[0]) begin
                ack_log.push_back(0);
                if (fq.size() == 0) chk("if_ack_unexpected", 1, 0);
                else begin
                    fe = fq.pop_front();
                    chk("if_rdata", if_rdata[0], fe);
                end
            end
            if (d_ack[0]) begin
                ack_log.push_back(1);
                if (dq.size() == 0) chk("d_ack_unexpected", 1, 0);
                else begin
                    de = dq.pop_front();
                    if (!de.we) begin
                        chk("d_rdata_load", d_rdata[0], de.data);
                        last_load <= de.data;
                    end else chk("d_rdata_store_held", d_rdata[0], last_load);
                end
            end
            if (mem_en[0]) begin
                men_cnt <= men_cnt + 1;
                men_cyc <= cyc;
                if (mem_we[0]) begin
                    wr_cnt  <= wr_cnt + 1;
                    wr_addr <= mem_addr[0];
                    wr_data <= mem_wdata[0];
                end
            end
        end
    end

    task automatic issue_f(input int i, input logic [31:0] a);
        if_req[i]  = 1'b1;
        if_addr[i] = a;
        if (i == 0) fq.push_back(mem_fn(a));
    endtask

    task automatic issue_d(input int i, input logic [31:0] a, input logic we);
        dexp_t e;
        d_req[i]   = 1'b1;
        d_we[i]    = we;
        d_addr[i]  = a;
        d_wdata[i] = wd(a);
        if (i == 0) begin
            if (we) sb_mem[a[9:2]] = wd(a);
            e.we   = we;
            e.data = we ? 32'h0 : sb_mem[a[9:2]];
            dq.push_back(e);
        end
    endtask

    // Drives nf fetches and nd data accesses, re-requesting after each ack while work remains.
    task automatic serve(input int i, input int nf, input int nd, input logic [31:0] fa,
                         input logic [31:0] da, input logic we, input int budget,
                         output int f_first, output int d_first);
        bit done = 0;
        bit fs, ds;
        f_first = -1;
        d_first = -1;
        if (nf > 0) issue_f(i, fa);
        if (nd > 0) issue_d(i, da, we);
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            chk("if_stall", if_stall[i], if_req[i] & ~if_ack[i]);
            chk("d_stall", d_stall[i], d_req[i] & ~d_ack[i]);
            fs = if_ack[i] & if_req[i];
            ds = d_ack[i] & d_req[i];
            if (fs && f_first < 0) f_first = cyc;
            if (ds && d_first < 0) d_first = cyc;
            @(posedge clk); #1;
            if (fs) begin
                nf--;
                if (nf > 0) issue_f(i, if_addr[i] + 32'd4); else if_req[i] = 1'b0;
            end
            if (ds) begin
                nd--;
                if (nd > 0) issue_d(i, d_addr[i] + 32'd4, we); else d_req[i] = 1'b0;
            end
            if (!if_req[i] && !d_req[i]) done = 1;
        end
        if (!done) begin
            chk("serve_timeout", 0, 1);
            if_req[i] = 1'b0;
            d_req[i]  = 1'b0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, f, d;
        for (int i = 0; i < NI; i++) begin
            if_addr[i] = '0; d_addr[i] = '0; d_wdata[i] = '0;
        end
        for (int k = 0; k < 256; k++) sb_mem[k] = mem_fn(32'(k * 4));
        repeat (3) @(posedge clk);
        #1 rst = '0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("reset_strobes", {mem_en[i], mem_we[i], if_ack[i], d_ack[i], if_stall[i], d_stall[i]}, 0);
            chk("reset_mem_addr", mem_addr[i], 0);
            chk("reset_rdata", {if_rdata[i], d_rdata[i]}, 0);
            chk("reset_mem_wdata", mem_wdata[i], 0);
        end
        @(posedge clk); #1;

        // Fetch only.
        t0 = cyc;
        serve(0, 1, 0, 32'h10, 32'h0, 1'b0, 20, f, d);
        chk("t1_if_latency", f - t0, 4);
        chk("t1_mem_en_cycle", men_cyc - t0, 1);
        chk("t1_if_rdata", if_rdata[0], 32'h8C01_0004);

        // Simultaneous requests: data first, then fetch.
        t0 = cyc;
        serve(0, 1, 1, 32'h14, 32'h20, 1'b0, 40, f, d);
        chk("t2_d_ack_cycle", d - t0, 4);
        chk("t2_if_ack_cycle", f - t0, 9);
        chk("t2_fetch_mem_en", men_cyc - t0, 6);

        // Continuous contention alternates grants.
        ack_log.delete();
        serve(0, 3, 3, 32'h100, 32'h200, 1'b0, 100, f, d);
        chk("t3_grant_count", ack_log.size(), 6);
        for (int k = 0; k < 6 && k < ack_log.size(); k++)
            chk($sformatf("t3_grant_%0d", k), ack_log[k], (k % 2 == 0) ? 1 : 0);

        // Store, then load it back.
        t0 = cyc;
        wr_cnt = wr_cnt;
        begin
            int wc0 = wr_cnt;
            serve(0, 0, 1, 32'h0, 32'h24, 1'b1, 20, f, d);
            chk("t4_store_ack_cycle", d - t0, 4);
            chk("t4_write_pulses", wr_cnt - wc0, 1);
        end
        chk("t4_write_addr", wr_addr, 32'h24);
        chk("t4_write_data", wr_data, 32'hDEAD_BEEF);
        chk("t4_d_rdata_kept", d_rdata[0], mem_fn(32'h208));
        serve(0, 0, 1, 32'h0, 32'h24, 1'b0, 20, f, d);

        // Kill in first WAIT cycle: no ack, then arbiter free at RESP+1.
        t0 = cyc;
        if_req[0] = 1'b1; if_addr[0] = 32'h30;
        repeat (2) begin @(posedge clk); #1; end
        if_kill[0] = 1'b1; if_req[0] = 1'b0;
        @(posedge clk); #1;
        if_kill[0] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("t5_no_if_ack", if_ack[0], 0);
            @(posedge clk); #1;
        end
        chk("t5_killed_mem_en", men_cyc - t0, 1);
        chk("t5_if_rdata_held", if_rdata[0], mem_fn(32'h108));
        t0 = cyc;
        serve(0, 1, 0, 32'h40, 32'h0, 1'b0, 20, f, d);
        chk("t5_refetch_latency", f - t0, 4);

        // Async reset in WAIT on each latency variant.
        for (int i = 0; i < NI; i++) begin
            if (i != 0) begin
                t0 = cyc;
                serve(i, 1, 0, 32'h50, 32'h0, 1'b0, 60, f, d);
                chk($sformatf("t6_pre_latency_%0d", i), f - t0, lat_of(i) + 2);
                chk($sformatf("t6_pre_rdata_%0d", i), if_rdata[i], mem_fn(32'h50));
            end
            if_req[i] = 1'b1; if_addr[i] = 32'h54;
            repeat (2) begin @(posedge clk); #1; end
            chk($sformatf("t6_addr_before_rst_%0d", i), mem_addr[i], 32'h54);
            #2;
            if_req[i] = 1'b0;
            rst[i] = 1'b1;
            #1;
            chk($sformatf("t6_rst_strobes_%0d", i),
                {mem_en[i], mem_we[i], if_ack[i], d_ack[i], if_stall[i], d_stall[i]}, 0);
            chk($sformatf("t6_rst_mem_addr_%0d", i), mem_addr[i], 0);
            chk($sformatf("t6_rst_rdata_%0d", i), {if_rdata[i], d_rdata[i]}, 0);
            chk($sformatf("t6_rst_mem_wdata_%0d", i), mem_wdata[i], 0);
            @(posedge clk); #1;
            rst[i] = 1'b0;
            @(posedge clk); #1;
            t0 = cyc;
            serve(i, 1, 0, 32'h58, 32'h0, 1'b0, 60, f, d);
            chk($sformatf("t6_post_latency_%0d", i), f - t0, lat_of(i) + 2);
            chk($sformatf("t6_post_rdata_%0d", i), if_rdata[i], mem_fn(32'h58));
        end

        repeat (3) @(posedge clk);
        chk("end_scoreboard_empty", fq.size() + dq.size(), 0);
        chk("end_mem_en_count", men_cnt, 15);
        chk("end_write_count", wr_cnt, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
